mem_port_arbiter: RTL

- Shares the single-port, byte-lane-writable word RAM between the instruction-fetch port and the load/store data port of the core.
- Arbitrates between the two requesters and converts byte addresses to RAM word addresses.
- Generates write strobes and replicated write data for SB/SH/SW.
- Aligns and sign/zero-extends load data, and tracks the RAM's 1-cycle registered read latency.

---
 rtl/mem_arb_pkg.sv | 46 ++++
 rtl/load_align.sv | 35 +++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared funct3 codes, response record and access checker for the
//            instruction/data memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic SRC_IF = 1'b0;
   localparam logic SRC_D  = 1'b1;

   typedef struct packed {
      logic       src;
      logic [2:0] f3;
      logic [1:0] off;
      logic       err;
      logic       valid;
   } resp_t;

   // Unsigned widths only exist for loads, so they are illegal for stores.
   function automatic logic access_err(input logic       we,
                                       input logic [2:0] f3,
                                       input logic [1:0] off);
      logic err;
      case (f3)
         F3_B:    err = 1'b0;
         F3_BU:   err = we;
         F3_H:    err = off[0];
         F3_HU:   err = we | off[0];
         F3_W:    err = (off != 2'b00);
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module   : load_align
// Purpose  : Extracts the addressed byte/halfword/word lane of a RAM word and
//            sign- or zero-extends it according to funct3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
   import mem_arb_pkg::*;
(
   input  logic [31:0] ram_dout,
   input  logic [2:0]  f3,
   input  logic [1:0]  off,
   output logic [31:0] rdata
);

   logic [31:0] w_shifted;

   assign w_shifted = ram_dout >> {off, 3'b000};

   always_comb begin
      rdata = w_shifted;
      case (f3)
         F3_B:    rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
         F3_BU:   rdata = {24'h0, w_shifted[7:0]};
         F3_H:    rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_HU:   rdata = {16'h0, w_shifted[15:0]};
         default: rdata = w_shifted;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one byte-writable word RAM between fetch and load/store
//            ports; optional grant statistics under MEM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_funct3,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
`ifdef MEM_ARB_STATS_EN
   output logic [31:0]       stat_if_gnt,
   output logic [31:0]       stat_d_gnt,
   output logic [31:0]       stat_conflict,
`endif
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_read,
   output logic [3:0]        ram_write,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout
);

   localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

   logic [3:0]  r_starve_cnt;
   resp_t       r_resp;
   logic        r_store;
   logic        w_d_err;
   logic [1:0]  w_d_off;
   logic [31:0] w_ld_data;
   logic        w_unused;

   assign w_d_off  = d_addr[1:0];
   assign w_d_err  = access_err(d_we, d_funct3, w_d_off);
   assign if_gnt   = if_req & (~d_req | (r_starve_cnt == C_STARVE_MAX));
   assign d_gnt    = d_req & ~if_gnt;
   assign w_unused = ^{if_addr, d_addr};

   always_comb begin
      ram_addr  = '0;
      ram_read  = 1'b0;
      ram_write = 4'b0000;
      ram_din   = 32'h0;
      if (if_gnt) begin
         ram_addr = if_addr[ADDR_W+1:2];
         ram_read = 1'b1;
      end else if (d_gnt && !w_d_err) begin
         ram_addr = d_addr[ADDR_W+1:2];
         if (!d_we) begin
            ram_read = 1'b1;
         end else begin
            case (d_funct3)
               F3_B: begin
                  ram_write = 4'b0001 << w_d_off;
                  ram_din   = {4{d_wdata[7:0]}};
               end
               F3_H: begin
                  ram_write = 4'b0011 << w_d_off;
                  ram_din   = {2{d_wdata[15:0]}};
               end
               default: begin
                  ram_write = 4'b1111;
                  ram_din   = d_wdata;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve_cnt <= 4'd0;
         r_resp       <= '0;
         r_store      <= 1'b0;
      end else begin
         if (!if_req || if_gnt)
            r_starve_cnt <= 4'd0;
         else if (r_starve_cnt != C_STARVE_MAX)
            r_starve_cnt <= r_starve_cnt + 4'd1;

         r_resp.valid <= if_gnt | d_gnt;
         r_resp.src   <= if_gnt ? SRC_IF : SRC_D;
         r_resp.f3    <= d_funct3;
         r_resp.off   <= w_d_off;
         r_resp.err   <= d_gnt & w_d_err;
         r_store      <= d_gnt & d_we;
      end
   end

   load_align u_load_align (
      .ram_dout (ram_dout),
      .f3       (r_resp.f3),
      .off      (r_resp.off),
      .rdata    (w_ld_data)
   );

   // Read data is forced to zero outside a valid load so stale RAM output never leaks.
   assign if_rvalid = r_resp.valid & (r_resp.src == SRC_IF);
   assign if_rdata  = if_rvalid ? ram_dout : 32'h0;
   assign d_rvalid  = r_resp.valid & (r_resp.src == SRC_D);
   assign d_err     = d_rvalid & r_resp.err;
   assign d_rdata   = (d_rvalid && !r_resp.err && !r_store) ? w_ld_data : 32'h0;

`ifdef MEM_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_if_gnt   <= 32'h0;
         stat_d_gnt    <= 32'h0;
         stat_conflict <= 32'h0;
      end else begin
         if (if_gnt)
            stat_if_gnt <= stat_if_gnt + 32'd1;
         if (d_gnt)
            stat_d_gnt <= stat_d_gnt + 32'd1;
         if (if_req && d_req)
            stat_conflict <= stat_conflict + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire
